// File: rtl/flash_page_writer.sv
// flash_page_writer: SPI initiator that sends WREN, PAGE PROGRAM of 32 bytes, then polls RDSR until WIP clears
module flash_page_writer #(
  parameter int          CLK_DIV    = 1,
  parameter int          CS_GAP     = 4,
  parameter logic [31:0] POLL_LIMIT = 32'd2000000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [23:0]  writeAddress,
  input  logic [255:0] dataOut,
  output logic         flashClk,
  output logic         flashMosi,
  input  logic         flashMiso,
  output logic         flashCs,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [7:0]   status
);
  typedef enum logic [2:0] {IDLE, WREN, GAP_A, PROG, GAP_B, POLL, FINISH} state_t;
  state_t state;
  logic [23:0] addrReg;
  logic [255:0] dataReg, payload;
  logic [287:0] shiftReg;
  logic [15:0] divCnt, gapCnt;
  logic [8:0] bitCnt;
  logic [2:0] rxCnt;
  logic [6:0] rxShift;
  logic [7:0] rxByte;
  logic [31:0] pollCnt;
  logic byteDone, errFlag, phaseEnd, pollStop, lastBit;
  for (genvar k = 0; k < 32; k++) begin : g_payload
    assign payload[255-8*k -: 8] = dataReg[8*k +: 8];
  end
  assign phaseEnd = divCnt == 16'(CLK_DIV - 1);
  assign rxByte = {rxShift, flashMiso};
  assign pollStop = byteDone && (!status[0] || pollCnt >= POLL_LIMIT);
  assign lastBit = state == WREN ? bitCnt == 9'd7 : state == PROG ? bitCnt == 9'd287 : pollStop;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      flashCs <= 1'b1;
      flashClk <= 1'b0;
      flashMosi <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      status <= 8'd0;
      addrReg <= '0;
      dataReg <= '0;
      shiftReg <= '0;
      divCnt <= '0;
      gapCnt <= '0;
      bitCnt <= '0;
      rxCnt <= '0;
      rxShift <= '0;
      pollCnt <= '0;
      byteDone <= 1'b0;
      errFlag <= 1'b0;
    end else begin
      done <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: if (start) begin
          addrReg <= writeAddress;
          dataReg <= dataOut;
          busy <= 1'b1;
          errFlag <= writeAddress[7:0] > 8'd224;
          if (writeAddress[7:0] > 8'd224) state <= FINISH;
          else begin
            state <= WREN;
            flashCs <= 1'b0;
            flashMosi <= 1'b0;
            shiftReg <= {8'h06, 280'd0};
            divCnt <= '0;
            bitCnt <= '0;
          end
        end
        GAP_A: if (gapCnt == 16'(CS_GAP - 1)) begin
          state <= PROG;
          flashCs <= 1'b0;
          flashMosi <= 1'b0;
          shiftReg <= {8'h02, addrReg, payload};
          divCnt <= '0;
          bitCnt <= '0;
        end else gapCnt <= gapCnt + 16'd1;
        GAP_B: if (gapCnt == 16'(CS_GAP - 1)) begin
          state <= POLL;
          flashCs <= 1'b0;
          flashMosi <= 1'b0;
          shiftReg <= {8'h05, 280'd0};
          divCnt <= '0;
          bitCnt <= '0;
          rxCnt <= '0;
          pollCnt <= '0;
          byteDone <= 1'b0;
        end else gapCnt <= gapCnt + 16'd1;
        WREN, PROG, POLL: begin
          divCnt <= phaseEnd ? 16'd0 : divCnt + 16'd1;
          if (phaseEnd && !flashClk) begin
            flashClk <= 1'b1;
            // status bits are only collected once the RDSR opcode has gone out
            if (state == POLL && bitCnt == 9'd8) begin
              rxShift <= rxByte[6:0];
              rxCnt <= rxCnt + 3'd1;
              if (rxCnt == 3'd7) begin
                status <= rxByte;
                pollCnt <= pollCnt + 32'd1;
                byteDone <= 1'b1;
              end
            end
          end else if (phaseEnd) begin
            flashClk <= 1'b0;
            byteDone <= 1'b0;
            if (state != POLL || bitCnt < 9'd8) bitCnt <= bitCnt + 9'd1;
            if (lastBit) begin
              flashCs <= 1'b1;
              flashMosi <= 1'b0;
              gapCnt <= '0;
              state <= state == WREN ? GAP_A : state == PROG ? GAP_B : FINISH;
              if (state == POLL) errFlag <= status[0];
            end else begin
              flashMosi <= shiftReg[286];
              shiftReg <= shiftReg << 1;
            end
          end
        end
        FINISH: begin
          done <= 1'b1;
          error <= errFlag;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
